// File: rtl/mov_tablero_seq_pkg.sv
// Shared types for the 2048 move engine: direction encoding and FSM states.
// The optional score datapath is enabled by defining MOV_SCORE_EN.
package mov_pkg;

    localparam logic [1:0] DIR_IZQ = 2'b00;
    localparam logic [1:0] DIR_DER = 2'b01;
    localparam logic [1:0] DIR_ARR = 2'b10;
    localparam logic [1:0] DIR_ABA = 2'b11;

    typedef enum logic [1:0] {
        IZQUIERDA = DIR_IZQ,
        DERECHA   = DIR_DER,
        ARRIBA    = DIR_ARR,
        ABAJO     = DIR_ABA
    } dir_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PROC = 2'b01,
        ST_FIN  = 2'b10
    } state_t;

endpackage

// File: rtl/mov_tablero_seq_comprimir_linea.sv
// Combinational compact-and-merge of one N-cell line toward index 0.
// Returns the new line and the sum of the tiles created by merges.
module comprimir_linea
    import mov_pkg::*;
#(
    parameter int N      = 4,
    parameter int CELL_W = 16,
    parameter int LS_W   = CELL_W + $clog2(N)
) (
    input  logic [N*CELL_W-1:0] line_i,
    output logic [N*CELL_W-1:0] line_o,
    output logic [LS_W-1:0]     score_o
);

    localparam logic [CELL_W-1:0] SAT_VAL = {1'b1, {(CELL_W-1){1'b0}}};

    // One extra zero slot so the pair lookahead never runs off the end.
    logic [CELL_W-1:0] comp [N+1];

    always_comb begin
        int                cnt;
        int                j;
        logic              skip;
        logic [CELL_W-1:0] dbl;
        for (int i = 0; i <= N; i++) comp[i] = '0;
        line_o  = '0;
        score_o = '0;
        cnt     = 0;
        j       = 0;
        skip    = 1'b0;
        dbl     = '0;
        for (int i = 0; i < N; i++) begin
            if (line_i[i*CELL_W +: CELL_W] != '0) begin
                comp[cnt] = line_i[i*CELL_W +: CELL_W];
                cnt++;
            end
        end
        // A merged tile consumes its partner, so the next slot is skipped.
        for (int i = 0; i < N; i++) begin
            if (skip) begin
                skip = 1'b0;
            end else if (comp[i] != '0) begin
                if (comp[i] == comp[i+1] && comp[i] < SAT_VAL) begin
                    dbl     = comp[i] << 1;
                    line_o[j*CELL_W +: CELL_W] = dbl;
                    score_o = score_o + {{(LS_W-CELL_W){1'b0}}, dbl};
                    skip    = 1'b1;
                end else begin
                    line_o[j*CELL_W +: CELL_W] = comp[i];
                end
                j++;
            end
        end
    end

endmodule

// File: rtl/mov_tablero_seq.sv
// Sequential 2048 move engine: one line per cycle, start/done handshake.
// Define MOV_SCORE_EN to build the saturating score accumulator.
module mov_tablero_seq
    import mov_pkg::*;
#(
    parameter int N       = 4,
    parameter int CELL_W  = 16,
    parameter int SCORE_W = 20
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [1:0]            dir,
    input  logic [N*N*CELL_W-1:0] board_in,
    output logic [N*N*CELL_W-1:0] board_out,
    output logic                  busy,
    output logic                  done,
    output logic                  moved,
    output logic [SCORE_W-1:0]    score
);

    localparam int              BW     = N*N*CELL_W;
    localparam int              CNT_W  = $clog2(N);
    localparam int              LS_W   = CELL_W + $clog2(N);
    localparam logic [CNT_W-1:0] K_LAST = CNT_W'(N-1);

    state_t              state_q;
    dir_t                dir_q;
    logic [CNT_W-1:0]    k_q;
    logic [BW-1:0]       orig_q;
    logic [BW-1:0]       work_q;
    logic [BW-1:0]       work_d;
    logic [BW-1:0]       board_out_q;
    logic                busy_q;
    logic                done_q;
    logic                moved_q;
    logic [N*CELL_W-1:0] line_in;
    logic [N*CELL_W-1:0] line_out;
    logic [LS_W-1:0]     line_score;

    // Maps line position i of line k to a board cell, folding in reversal.
    function automatic int cell_idx(input dir_t d, input int k, input int i);
        case (d)
            IZQUIERDA: return k*N + i;
            DERECHA:   return k*N + (N-1-i);
            ARRIBA:    return i*N + k;
            default:   return (N-1-i)*N + k;
        endcase
    endfunction

    always_comb begin
        line_in = '0;
        work_d  = work_q;
        for (int i = 0; i < N; i++) begin
            line_in[i*CELL_W +: CELL_W] =
                work_q[cell_idx(dir_q, int'(k_q), i)*CELL_W +: CELL_W];
        end
        for (int i = 0; i < N; i++) begin
            work_d[cell_idx(dir_q, int'(k_q), i)*CELL_W +: CELL_W] =
                line_out[i*CELL_W +: CELL_W];
        end
    end

    comprimir_linea #(
        .N      (N),
        .CELL_W (CELL_W),
        .LS_W   (LS_W)
    ) u_linea (
        .line_i  (line_in),
        .line_o  (line_out),
        .score_o (line_score)
    );

    // Working copies carry no reset; they are always loaded before use.
    always_ff @(posedge clk) begin
        if (state_q == ST_IDLE && start) begin
            orig_q <= board_in;
            work_q <= board_in;
            dir_q  <= dir_t'(dir);
        end else if (state_q == ST_PROC) begin
            work_q <= work_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            k_q         <= '0;
            board_out_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            moved_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        k_q     <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_PROC;
                    end
                end
                ST_PROC: begin
                    if (k_q == K_LAST) state_q <= ST_FIN;
                    else               k_q     <= k_q + 1'b1;
                end
                ST_FIN: begin
                    board_out_q <= work_q;
                    moved_q     <= (work_q != orig_q);
                    done_q      <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign board_out = board_out_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign moved     = moved_q;

`ifdef MOV_SCORE_EN
    localparam int SUM_W = ((SCORE_W > LS_W) ? SCORE_W : LS_W) + 1;

    logic [SCORE_W-1:0] acc_q;
    logic [SCORE_W-1:0] score_q;

    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                   input logic [LS_W-1:0]    b);
        logic [SUM_W-1:0] s;
        s = SUM_W'(a) + SUM_W'(b);
        if (s > SUM_W'({SCORE_W{1'b1}})) return '1;
        return s[SCORE_W-1:0];
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q   <= '0;
            score_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: if (start) acc_q <= '0;
                ST_PROC: acc_q   <= sat_add(acc_q, line_score);
                ST_FIN:  score_q <= acc_q;
                default: acc_q   <= acc_q;
            endcase
        end
    end

    assign score = score_q;
`else
    logic unused_line_score;
    assign unused_line_score = ^line_score;
    assign score             = '0;
`endif

endmodule

// File: tb/tb_mov_tablero_seq.sv
// Directed bench for mov_tablero_seq: a 16-bit-cell instance plus a 4-bit-cell
// instance for tile saturation. Expected score follows MOV_SCORE_EN.
module tb_mov_tablero_seq;

`ifdef MOV_SCORE_EN
    localparam bit SC_EN = 1'b1;
`else
    localparam bit SC_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start1, start2;
    logic [1:0]   dir1, dir2;
    logic [255:0] b_in, b_out;
    logic [63:0]  s_in, s_out;
    logic         busy1, done1, moved1, busy2, done2, moved2;
    logic [19:0]  score1, score2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mov_tablero_seq #(.N(4), .CELL_W(16), .SCORE_W(20)) dut (
        .clk(clk), .rst_n(rst_n), .start(start1), .dir(dir1), .board_in(b_in),
        .board_out(b_out), .busy(busy1), .done(done1), .moved(moved1), .score(score1)
    );

    mov_tablero_seq #(.N(4), .CELL_W(4), .SCORE_W(20)) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(start2), .dir(dir2), .board_in(s_in),
        .board_out(s_out), .busy(busy2), .done(done2), .moved(moved2), .score(score2)
    );

    function automatic logic [63:0] r16(input int a, input int b, input int c, input int d);
        return {16'(d), 16'(c), 16'(b), 16'(a)};
    endfunction

    function automatic logic [15:0] r4(input int a, input int b, input int c, input int d);
        return {4'(d), 4'(c), 4'(b), 4'(a)};
    endfunction

    // Called just after a rising edge; returns edges from acceptance to done (-1 on timeout).
    task automatic run_move(input bit sel, input logic [1:0] d, input logic [255:0] b,
                            input logic [63:0] sb, output int lat);
        if (sel) begin start2 = 1'b1; dir2 = d; s_in = sb; end
        else     begin start1 = 1'b1; dir1 = d; b_in = b;  end
        @(posedge clk); #1;
        start1 = 1'b0;
        start2 = 1'b0;
        b_in   = ~b;
        s_in   = ~sb;
        lat    = -1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (sel ? done2 : done1) begin lat = c; break; end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start1 = 1'b0; start2 = 1'b0;
        dir1 = 2'b00; dir2 = 2'b00; b_in = '0; s_in = '0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if ({b_out, busy1, done1, moved1, score1} !== '0) begin
            n_fail++; $display("FAIL reset_outputs: got busy=%b done=%b moved=%b score=%0d board=%h, need all 0",
                               busy1, done1, moved1, score1, b_out);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if ({busy1, done1, busy2, done2} !== 4'b0) begin
            n_fail++; $display("FAIL reset_idle: got busy=%b done=%b, need 0 0", busy1, done1);
        end
    endtask

    task automatic test_derecha;
        int lat;
        logic [255:0] exp_b;
        exp_b = {r16(0,4,4,4), r16(0,0,4,4), r16(0,0,4,4), r16(0,0,0,4)};
        run_move(1'b0, 2'b01, {r16(4,2,2,4), r16(2,2,4,0), r16(0,4,2,2), r16(0,2,2,0)}, '0, lat);
        n_tests++;
        if (lat !== 5) begin n_fail++; $display("FAIL derecha_latency: got %0d need 5", lat); end
        n_tests++;
        if (b_out !== exp_b) begin n_fail++; $display("FAIL derecha_board: got %h need %h", b_out, exp_b); end
        n_tests++;
        if (moved1 !== 1'b1 || score1 !== (SC_EN ? 20'd16 : 20'd0)) begin
            n_fail++; $display("FAIL derecha_flags: got moved=%b score=%0d need moved=1 score=%0d",
                               moved1, score1, SC_EN ? 16 : 0);
        end
        @(posedge clk); #1;
        n_tests++;
        if (done1 !== 1'b0 || busy1 !== 1'b0 || b_out !== exp_b) begin
            n_fail++; $display("FAIL derecha_after: got done=%b busy=%b need 0 0 with board held", done1, busy1);
        end
    endtask

    task automatic test_izquierda;
        int lat;
        logic [255:0] exp_b;
        exp_b = {r16(0,0,0,0), r16(8,8,0,0), r16(4,2,0,0), r16(4,4,0,0)};
        run_move(1'b0, 2'b00, {r16(0,0,0,0), r16(4,4,8,0), r16(2,2,2,0), r16(2,2,2,2)}, '0, lat);
        n_tests++;
        if (lat !== 5 || b_out !== exp_b) begin
            n_fail++; $display("FAIL izquierda_board: got lat=%0d %h need lat=5 %h", lat, b_out, exp_b);
        end
        n_tests++;
        if (moved1 !== 1'b1 || score1 !== (SC_EN ? 20'd20 : 20'd0)) begin
            n_fail++; $display("FAIL izquierda_flags: got moved=%b score=%0d need moved=1 score=%0d",
                               moved1, score1, SC_EN ? 20 : 0);
        end
    endtask

    task automatic test_vertical;
        int lat;
        logic [255:0] src;
        src = {r16(2,0,0,0), r16(0,0,0,0), r16(2,0,0,0), r16(0,0,0,0)};
        run_move(1'b0, 2'b10, src, '0, lat);
        n_tests++;
        if (lat !== 5 || b_out !== {192'd0, r16(4,0,0,0)} || score1 !== (SC_EN ? 20'd4 : 20'd0)) begin
            n_fail++; $display("FAIL arriba: got lat=%0d score=%0d %h need lat=5 score=%0d col0 top=4",
                               lat, score1, b_out, SC_EN ? 4 : 0);
        end
        run_move(1'b0, 2'b11, src, '0, lat);
        n_tests++;
        if (lat !== 5 || b_out !== {r16(4,0,0,0), 192'd0} || moved1 !== 1'b1) begin
            n_fail++; $display("FAIL abajo: got lat=%0d moved=%b %h need lat=5 moved=1 col0 bottom=4",
                               lat, moved1, b_out);
        end
    endtask

    task automatic test_no_move;
        int lat;
        logic [255:0] src;
        src = {r16(0,0,0,0), r16(8,0,0,0), r16(4,2,0,0), r16(2,4,8,16)};
        run_move(1'b0, 2'b00, src, '0, lat);
        n_tests++;
        if (lat !== 5 || b_out !== src || moved1 !== 1'b0 || score1 !== 20'd0) begin
            n_fail++; $display("FAIL no_move: got lat=%0d moved=%b score=%0d %h need lat=5 moved=0 score=0 %h",
                               lat, moved1, score1, b_out, src);
        end
    endtask

    task automatic test_saturation;
        int lat;
        logic [63:0] src;
        src = {48'd0, r4(8,8,0,0)};
        run_move(1'b1, 2'b00, '0, src, lat);
        n_tests++;
        if (lat !== 5 || s_out !== src || moved2 !== 1'b0 || score2 !== 20'd0) begin
            n_fail++; $display("FAIL saturation: got lat=%0d moved=%b score=%0d %h need lat=5 moved=0 score=0 %h",
                               lat, moved2, score2, s_out, src);
        end
        run_move(1'b1, 2'b00, '0, {48'd0, r4(4,4,0,0)}, lat);
        n_tests++;
        if (s_out !== {48'd0, r4(8,0,0,0)} || moved2 !== 1'b1 || score2 !== (SC_EN ? 20'd8 : 20'd0)) begin
            n_fail++; $display("FAIL below_saturation: got moved=%b score=%0d %h need moved=1 score=%0d row0=8",
                               moved2, score2, s_out, SC_EN ? 8 : 0);
        end
    endtask

    task automatic test_back_to_back;
        int ndone;
        int lat;
        ndone  = 0;
        start1 = 1'b1; dir1 = 2'b00; b_in = {192'd0, r16(0,0,2,2)};
        @(posedge clk); #1;
        n_tests++;
        if (busy1 !== 1'b1) begin n_fail++; $display("FAIL busy_after_accept: got %b need 1", busy1); end
        for (int c = 0; c < 20 && ndone == 0; c++) begin
            @(posedge clk); #1;
            if (done1) ndone++;
        end
        start1 = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (done1) ndone++;
        end
        n_tests++;
        if (ndone !== 1 || b_out !== {192'd0, r16(4,0,0,0)}) begin
            n_fail++; $display("FAIL start_held: got %0d done pulses board %h need 1 and row0=4", ndone, b_out);
        end
        run_move(1'b0, 2'b01, {192'd0, r16(2,0,0,2)}, '0, lat);
        n_tests++;
        if (lat !== 5 || b_out !== {192'd0, r16(0,0,0,4)}) begin
            n_fail++; $display("FAIL next_move: got lat=%0d %h need lat=5 row0 right=4", lat, b_out);
        end
    endtask

    task automatic test_reset_mid;
        int ndone;
        int lat;
        ndone  = 0;
        start1 = 1'b1; dir1 = 2'b00; b_in = {192'd0, r16(2,2,0,0)};
        @(posedge clk); #1;
        start1 = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({b_out, busy1, done1, moved1, score1} !== '0) begin
            n_fail++; $display("FAIL reset_mid_outputs: got busy=%b done=%b moved=%b score=%0d board=%h need all 0",
                               busy1, done1, moved1, score1, b_out);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            if (done1) ndone++;
        end
        n_tests++;
        if (ndone !== 0 || busy1 !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_abort: got %0d done pulses busy=%b need 0 0", ndone, busy1);
        end
        run_move(1'b0, 2'b00, {192'd0, r16(0,2,0,2)}, '0, lat);
        n_tests++;
        if (lat !== 5 || b_out !== {192'd0, r16(4,0,0,0)} || moved1 !== 1'b1) begin
            n_fail++; $display("FAIL reset_mid_recover: got lat=%0d moved=%b %h need lat=5 moved=1 row0=4",
                               lat, moved1, b_out);
        end
    endtask

    initial begin
        test_reset();
        test_derecha();
        test_izquierda();
        test_vertical();
        test_no_move();
        test_saturation();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, need completion");
        $fatal(1);
    end

endmodule
